// File: rtl/classify_multi.sv
// rtl/classify_multi.sv - multi-channel I/Q line-side classifier with stream and batch-histogram output
module classify_multi #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                     clk100,
    input  logic                     reset,
    input  logic                     data_in,
    input  logic [NUM_CH*DATA_W-1:0] i_val,
    input  logic [NUM_CH*DATA_W-1:0] q_val,
    input  logic [NUM_CH*DATA_W-1:0] i_pt_line,
    input  logic [NUM_CH*DATA_W-1:0] q_pt_line,
    input  logic [NUM_CH*DATA_W-1:0] i_vec_perp,
    input  logic [NUM_CH*DATA_W-1:0] q_vec_perp,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic                     stream_mode,
    input  logic [CNT_W-1:0]         num_data_pts,
    input  logic                     start,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [NUM_CH-1:0]        state_bits,
    output logic [NUM_CH*CNT_W-1:0]  count_one,
    output logic                     busy,
    output logic                     overflow
);

    localparam int DW1 = DATA_W + 1;
    localparam int PW  = 2*DATA_W + 2;
    localparam int SW  = 2*DATA_W + 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic              s1_valid;
    logic              s2_valid;
    logic [NUM_CH-1:0] s1_mask;
    logic [NUM_CH-1:0] s2_mask;
    logic [NUM_CH-1:0] res_bits;

    logic [1:0]        state;
    logic              mode_stream;
    logic              eff_stream;
    logic [CNT_W-1:0]  shot_cnt;
    logic [CNT_W-1:0]  shot_next;
    logic [CNT_W-1:0]  target;

    // Stage 1 registers the differences, stage 2 the products; the sum and
    // sign test are combinational and land in the output/counter registers.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        logic signed [DATA_W-1:0] iv, qv, ip, qp, vi, vq;
        logic signed [DW1-1:0]    s1_di, s1_dq;
        logic signed [DATA_W-1:0] s1_vi, s1_vq;
        logic signed [PW-1:0]     s2_pi, s2_pq;
        logic signed [SW-1:0]     sum;

        assign iv = i_val[k*DATA_W +: DATA_W];
        assign qv = q_val[k*DATA_W +: DATA_W];
        assign ip = i_pt_line[k*DATA_W +: DATA_W];
        assign qp = q_pt_line[k*DATA_W +: DATA_W];
        assign vi = i_vec_perp[k*DATA_W +: DATA_W];
        assign vq = q_vec_perp[k*DATA_W +: DATA_W];

        always_ff @(posedge clk100) begin
            if (data_in) begin
                s1_di <= DW1'(iv) - DW1'(ip);
                s1_dq <= DW1'(qv) - DW1'(qp);
                s1_vi <= vi;
                s1_vq <= vq;
            end
            if (s1_valid) begin
                s2_pi <= PW'(s1_di) * PW'(s1_vi);
                s2_pq <= PW'(s1_dq) * PW'(s1_vq);
            end
        end

        assign sum         = SW'(s2_pi) + SW'(s2_pq);
        assign res_bits[k] = s2_mask[k] & ~sum[SW-1] & (|sum);
    end

    always_ff @(posedge clk100) begin
        s1_mask <= ch_mask;
        s2_mask <= s1_mask;
    end

    // The mode input only steers the block while it is idle with nothing pending.
    assign eff_stream = (state == ST_IDLE && !out_valid) ? stream_mode : mode_stream;
    assign shot_next  = shot_cnt + CNT_W'(1);
    assign busy       = (state == ST_ACCUM);

    always_ff @(posedge clk100) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            state       <= ST_IDLE;
            mode_stream <= 1'b0;
            shot_cnt    <= '0;
            target      <= '0;
            count_one   <= '0;
            state_bits  <= '0;
            out_valid   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            s1_valid <= data_in;
            s2_valid <= s1_valid;
            if (state == ST_IDLE && !out_valid) begin
                mode_stream <= stream_mode;
            end
            case (state)
                ST_IDLE: begin
                    if (eff_stream) begin
                        if (s2_valid) begin
                            if (!out_valid || out_ready) begin
                                state_bits <= res_bits;
                                out_valid  <= 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else if (out_valid && out_ready) begin
                            out_valid <= 1'b0;
                        end
                    end else if (start) begin
                        // Shots already in flight belong to no batch.
                        s2_valid  <= 1'b0;
                        target    <= num_data_pts;
                        shot_cnt  <= '0;
                        count_one <= '0;
                        if (num_data_pts == '0) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (s2_valid) begin
                        shot_cnt <= shot_next;
                        for (int k = 0; k < NUM_CH; k++) begin
                            count_one[k*CNT_W +: CNT_W] <= count_one[k*CNT_W +: CNT_W] + CNT_W'(res_bits[k]);
                        end
                        if (shot_next == target) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
